// File: rtl/tensor_arbiter.sv
// Round-robin arbiter sharing one tensor unit among four thread control units.
// Requests are latched into pending bits and served one at a time through IDLE -> ISSUE -> BUSY.
module tensor_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_start,
    input  logic [11:0] req_mode,
    input  logic [3:0]  req_relu,
    output logic        tu_start,
    output logic [2:0]  tu_op_mode,
    output logic        tu_relu_en,
    input  logic        tu_done,
    output logic [3:0]  req_done,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        err_spurious,
    output logic        err_timeout,
    output logic [1:0]  dbg_state
);

    // Handshake: all request/response signals are single-cycle pulses with no back-pressure;
    // req_start is captured unconditionally unless already pending, tu_done is honoured only in BUSY.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [11:0]   mode_q, mode_d;
    logic [3:0]    relu_q, relu_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    owner_q, owner_d;
    logic [2:0]    op_mode_q, op_mode_d;
    logic          relu_en_q, relu_en_d;
    logic [3:0]    req_done_q, req_done_d;
    logic          err_sp_q, err_sp_d;
    logic          err_to_q, err_to_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          finish;
    logic [3:0]    clr;
    logic [3:0]    accept;
    logic [1:0]    sel;
    logic [1:0]    idx;
    logic [2:0]    sel_mode;
    logic          sel_relu;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mode_d     = mode_q;
        relu_d     = relu_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        op_mode_d  = op_mode_q;
        relu_en_d  = relu_en_q;
        err_sp_d   = err_sp_q;
        err_to_d   = err_to_q;
        cnt_d      = cnt_q;
        idx        = 2'd0;
        sel        = rr_ptr_q;
        sel_mode   = 3'd0;
        sel_relu   = 1'b0;

        finish     = (state_q == BUSY) && (tu_done || (cnt_q == CNT_LAST));
        clr        = finish ? (4'b0001 << owner_q) : 4'b0000;
        req_done_d = clr;

        // A start arriving in the same cycle its pending bit clears is kept (set wins).
        accept    = req_start & (~pending_q | clr);
        pending_d = (pending_q & ~clr) | accept;
        for (int i = 0; i < 4; i++) begin
            if (accept[i]) begin
                mode_d[3*i +: 3] = req_mode[3*i +: 3];
                relu_d[i]        = req_relu[i];
            end
        end

        // Descending scan so the lowest offset from rr_ptr wins.
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_q + 2'(k);
            if (pending_q[idx]) sel = idx;
        end
        for (int i = 0; i < 4; i++) begin
            if (sel == 2'(i)) begin
                sel_mode = mode_q[3*i +: 3];
                sel_relu = relu_q[i];
            end
        end

        if (tu_done && (state_q != BUSY)) err_sp_d = 1'b1;

        case (state_q)
            IDLE: begin
                // Hold off one cycle while req_done is pulsing so grants are spaced by 3 cycles.
                if ((|pending_q) && (req_done_q == 4'b0000)) begin
                    state_d   = ISSUE;
                    owner_d   = sel;
                    op_mode_d = sel_mode;
                    relu_en_d = sel_relu;
                end
            end
            ISSUE: begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + 2'd1;
                    if (!tu_done) err_to_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 4'b0000;
            mode_q     <= 12'd0;
            relu_q     <= 4'b0000;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            op_mode_q  <= 3'd0;
            relu_en_q  <= 1'b0;
            req_done_q <= 4'b0000;
            err_sp_q   <= 1'b0;
            err_to_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            relu_q     <= relu_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            op_mode_q  <= op_mode_d;
            relu_en_q  <= relu_en_d;
            req_done_q <= req_done_d;
            err_sp_q   <= err_sp_d;
            err_to_q   <= err_to_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tu_start     = (state_q == ISSUE);
    assign tu_op_mode   = op_mode_q;
    assign tu_relu_en   = relu_en_q;
    assign req_done     = req_done_q;
    assign owner        = owner_q;
    assign busy         = (state_q != IDLE);
    assign err_spurious = err_sp_q;
    assign err_timeout  = err_to_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/tensor_arbiter.md
TENSOR_ARBITER -- requirements
Module: tensor_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 1024, meaning the maximum number of BUSY cycles allowed before an operation is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_start, input, 4, one-cycle start pulse per requester (thread control unit i).
REQ-005 SHALL have port req_mode, input, 12, 3-bit op mode per requester; requester i uses bits [3i+2:3i].
REQ-006 SHALL have port req_relu, input, 4, ReLU enable per requester.
REQ-007 SHALL have port tu_start, output, 1, one-cycle start pulse to the shared tensor unit.
REQ-008 SHALL have port tu_op_mode, output, 3, op mode presented to the tensor unit.
REQ-009 SHALL have port tu_relu_en, output, 1, ReLU enable presented to the tensor unit.
REQ-010 SHALL have port tu_done, input, 1, completion pulse from the tensor unit.
REQ-011 SHALL have port req_done, output, 4, one-hot one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port owner, output, 2, index of the current or most recent granted requester, for operand/result muxing.
REQ-013 SHALL have port busy, output, 1, high while in ISSUE or BUSY.
REQ-014 SHALL have port err_spurious, output, 1, sticky flag for tu_done received outside BUSY.
REQ-015 SHALL have port err_timeout, output, 1, sticky flag for a timeout abort.

Function
REQ-016 SHALL latch each req_start[i] into pending[i], capturing req_mode slice and req_relu[i] into per-requester holding registers in the same edge.
REQ-017 SHALL ignore req_start[i] while pending[i] is already set (holding registers unchanged).
REQ-018 SHALL implement states IDLE, ISSUE, BUSY.
REQ-019 IDLE: if any pending bit set, SHALL select the first set bit searching rr_ptr, rr_ptr+1, ... wrapping 3->0, load owner, drive tu_op_mode/tu_relu_en from that requester's holding registers, go to ISSUE.
REQ-020 ISSUE: SHALL assert tu_start for exactly this one cycle, clear the timeout counter, go to BUSY.
REQ-021 BUSY: tu_op_mode/tu_relu_en SHALL stay stable; timeout counter increments by 1 per cycle.
REQ-022 BUSY with tu_done=1: SHALL pulse req_done[owner] in the next cycle, clear pending[owner], set rr_ptr=owner+1 mod 4, go to IDLE.
REQ-023 BUSY with counter reaching TIMEOUT-1 and no tu_done: SHALL abort exactly as REQ-022 and additionally set err_timeout.
REQ-024 Latency: req_start high in cycle t with arbiter idle and no other pending -> tu_start high in cycle t+2; tu_done in cycle c -> req_done in cycle c+1; next tu_start no earlier than c+3.
REQ-025 tu_done in IDLE or ISSUE SHALL be ignored for grant purposes and SHALL set err_spurious.
REQ-026 req_start[i] in the same cycle pending[i] is cleared SHALL leave pending[i] set with new holding values (set wins).
REQ-027 Simultaneous req_start on several requesters SHALL all be latched; grants are then served in round-robin order, one at a time.

Reset
REQ-028 rst SHALL force state IDLE, pending=0, rr_ptr=0, owner=0, tu_start=0, tu_op_mode=0, tu_relu_en=0, req_done=0, busy=0, err_spurious=0, err_timeout=0, counter=0; holding registers cleared.
REQ-029 rst asserted mid-operation (ISSUE or BUSY) SHALL discard all pending requests without emitting req_done; a tu_done arriving after reset SHALL set err_spurious.

Verification
REQ-030 Single request: req_start[2]=1, mode=3'b101, relu=1 at cycle 0 -> tu_start=1, tu_op_mode=5, tu_relu_en=1, owner=2 at cycle 2; tu_done at cycle 10 -> req_done=4'b0100 at cycle 11.
REQ-031 All four requesters start in the same cycle, rr_ptr=0 -> grant order 0,1,2,3, each req_done exactly once, never two tu_start without an intervening tu_done.
REQ-032 Fairness: requester 0 re-requests immediately after every completion while requester 3 is pending -> requester 3 granted before requester 0's second grant.
REQ-033 Timeout: TIMEOUT=8, grant requester 1, withhold tu_done -> req_done=4'b0010 after 8 BUSY cycles, err_timeout=1, state IDLE.
REQ-034 Spurious: tu_done pulse while idle -> err_spurious=1, no req_done, no tu_start.
REQ-035 Reset mid-BUSY: rst during BUSY for owner 1 with requester 3 pending -> all outputs at reset values next cycle, no req_done, no subsequent tu_start.
